operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
// - Parametrised fetch->decode pipeline register with valid/ready handshake, flush and halt.
// - Generates all RV immediates (I/S/B/U/J) sign-extended to XLEN.
// - Decodes the opcode and drives one pre-selected immediate plus its format code.
// - Sits between instruction fetch and decode/execute; instruction width is always 32.
// PARAMETERS
// - XLEN        32  datapath/PC width; 32 or 64 (other values unsupported)
// - RESET_PC    0   value driven on pc_out while reset is asserted
// PORTS
// - clk              in   1     clock, all state on posedge
// - rst              in   1     asynchronous active-high reset
// - flush            in   1     kill held and incoming instruction (branch/trap redirect)
// - halt             in   1     freeze stage: no capture, no release, outputs held
// - in_valid         in   1     upstream instruction valid
// - in_ready         out  1     stage can accept this cycle
// - pc_in            in   XLEN  PC of incoming instruction
// - instruction_in   in   32    raw instruction word
// - out_valid        out  1     registered instruction valid to decode
// - out_ready        in   1     decode accepts this cycle
// - pc_out           out  XLEN  registered PC
// - instruction_out  out  32    registered instruction
// - imm_i/s/b/u/j    out  XLEN  per-format immediates, sign-extended from bit 31
// - imm_sel          out  XLEN  immediate matching decoded format, 0 if none
// - imm_fmt          out  3     0=NONE 1=I 2=S 3=B 4=U 5=J
// BEHAVIOUR
// - Reset (async, any cycle incl. mid-transfer): out_valid=0, pc_out=RESET_PC, instruction_out=32'h0000_0013 (NOP),
//   all imm_*=0, imm_fmt=0; skid entry (if built) invalidated. Released synchronously on next posedge.
// - Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready. Latency 1 cycle in->out.
// - in_ready = !halt & (!out_valid | out_ready) (combinational, no skid build).
// - Capture: on posedge with in transfer, all outputs load from inputs; immediates computed from instruction_in.
// - out_valid next = flush ? 0 : halt ? out_valid : (in xfer ? 1 : out xfer ? 0 : out_valid).
// - Data regs hold value when not capturing; outputs stable while out_valid & !out_ready.
// - flush wins over everything except rst: drops held entry and same-cycle input (input counts as consumed).
// - flush & halt together: flush applies (out_valid->0).
// - halt: in_ready=0, state frozen; out_valid held, decode must not count out xfer while halt (out_ready ignored).
// - Immediates: I={sx,i[30:20]}; S={sx,i[30:25],i[11:7]}; B={sx,i[7],i[30:25],i[11:8],0};
//   U={sx,i[31:12],12'b0}; J={sx,i[19:12],i[20],i[30:21],0}; sx = replicate i[31] to XLEN.
// - imm_fmt from opcode i[6:0]: 0000011,0010011,1100111,0011011 -> I; 0100011 -> S; 1100011 -> B;
//   0110111,0010111 -> U; 1101111 -> J; else NONE (imm_sel=0).
// - 0011011 (OP-IMM-32) decoded as I for both XLEN values.
// CONFIGURATION
// - OF_SKID_BUFFER_EN defined: one-entry skid buffer; in_ready=!skid_valid & !halt (registered, no out_ready path).
//   - Input arriving while output held (out_valid & !out_ready) goes to skid; skid drains to output on next out xfer.
//   - Order preserved; flush clears both entries; capacity 2; throughput 1/cycle under continuous out_ready.
// - OF_SKID_BUFFER_EN undefined: single register, combinational in_ready as above; identical results/latency otherwise.
// TESTING
// - Reset mid-stream: rst pulse asynchronous to clk while out_valid=1 -> out_valid=0, instruction_out=0x00000013 immediately.
// - XLEN=32: 0xFFF00093 (addi x1,x0,-1) -> imm_fmt=1, imm_sel=0xFFFFFFFF.
// - XLEN=32: 0xFFDFF06F (jal x0,-4) -> imm_fmt=5, imm_sel=0xFFFFFFFC.
// - XLEN=64: 0x123450B7 -> imm_sel=0x0000000012345000; 0x800000B7 -> 0xFFFFFFFF80000000.
// - Backpressure: out_ready=0 for 3 cycles, in_valid=1 with pc 0x100,0x104 -> pc_out holds 0x100, no loss/dup, order kept.
// - flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0; halt=1 -> in_ready=0, outputs frozen until halt=0.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Fetch->decode pipeline register with valid/ready handshake, flush, halt and RV immediate pre-decode.
// Define OF_SKID_BUFFER_EN to add a one-entry skid buffer (registered in_ready, capacity 2).
module operand_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            halt,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instruction_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     instruction_out,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_u,
    output logic [XLEN-1:0] imm_j,
    output logic [XLEN-1:0] imm_sel,
    output logic [2:0]      imm_fmt
);

    localparam logic [2:0]  FMT_NONE = 3'd0;
    localparam logic [2:0]  FMT_I    = 3'd1;
    localparam logic [2:0]  FMT_S    = 3'd2;
    localparam logic [2:0]  FMT_B    = 3'd3;
    localparam logic [2:0]  FMT_U    = 3'd4;
    localparam logic [2:0]  FMT_J    = 3'd5;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic            r_out_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_imm_i, r_imm_s, r_imm_b, r_imm_u, r_imm_j, r_imm_sel;
    logic [2:0]      r_imm_fmt;

    logic            w_in_ready;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_load;
    logic [XLEN-1:0] w_src_pc;
    logic [31:0]     w_src_instr;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sel;
    logic [2:0]      w_imm_fmt;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Decode sees no handshake while halted, so out_ready is masked here.
    assign w_out_xfer = r_out_valid & out_ready & ~halt;
    assign w_in_xfer  = in_valid & w_in_ready;

`ifdef OF_SKID_BUFFER_EN
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_pc;
    logic [31:0]     r_skid_instr;
    logic            w_out_free;
    logic            w_skid_load;

    assign w_in_ready  = ~r_skid_valid & ~halt;
    assign w_out_free  = ~r_out_valid | w_out_xfer;
    assign w_load      = ~flush & ~halt & w_out_free & (r_skid_valid | w_in_xfer);
    assign w_skid_load = ~flush & w_in_xfer & ~w_out_free;
    assign w_src_pc    = r_skid_valid ? r_skid_pc    : pc_in;
    assign w_src_instr = r_skid_valid ? r_skid_instr : instruction_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP;
        end else begin
            if (flush) begin
                r_skid_valid <= 1'b0;
            end else if (w_skid_load) begin
                r_skid_valid <= 1'b1;
            end else if (r_skid_valid && w_load) begin
                r_skid_valid <= 1'b0;
            end
            if (w_skid_load) begin
                r_skid_pc    <= pc_in;
                r_skid_instr <= instruction_in;
            end
        end
    end
`else
    assign w_in_ready  = ~halt & (~r_out_valid | out_ready);
    assign w_load      = ~flush & w_in_xfer;
    assign w_src_pc    = pc_in;
    assign w_src_instr = instruction_in;
`endif

    assign w_imm_i = sext32({{20{w_src_instr[31]}}, w_src_instr[31:20]});
    assign w_imm_s = sext32({{20{w_src_instr[31]}}, w_src_instr[31:25], w_src_instr[11:7]});
    assign w_imm_b = sext32({{19{w_src_instr[31]}}, w_src_instr[31], w_src_instr[7],
                             w_src_instr[30:25], w_src_instr[11:8], 1'b0});
    assign w_imm_u = sext32({w_src_instr[31:12], 12'h000});
    assign w_imm_j = sext32({{11{w_src_instr[31]}}, w_src_instr[31], w_src_instr[19:12],
                             w_src_instr[20], w_src_instr[30:21], 1'b0});

    always_comb begin
        w_imm_fmt = FMT_NONE;
        case (w_src_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011: w_imm_fmt = FMT_I;
            7'b0100011:                                     w_imm_fmt = FMT_S;
            7'b1100011:                                     w_imm_fmt = FMT_B;
            7'b0110111, 7'b0010111:                         w_imm_fmt = FMT_U;
            7'b1101111:                                     w_imm_fmt = FMT_J;
            default:                                        w_imm_fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        w_imm_sel = '0;
        case (w_imm_fmt)
            FMT_I:   w_imm_sel = w_imm_i;
            FMT_S:   w_imm_sel = w_imm_s;
            FMT_B:   w_imm_sel = w_imm_b;
            FMT_U:   w_imm_sel = w_imm_u;
            FMT_J:   w_imm_sel = w_imm_j;
            default: w_imm_sel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_pc        <= RESET_PC;
            r_instr     <= NOP;
            r_imm_i     <= '0;
            r_imm_s     <= '0;
            r_imm_b     <= '0;
            r_imm_u     <= '0;
            r_imm_j     <= '0;
            r_imm_sel   <= '0;
            r_imm_fmt   <= FMT_NONE;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (!halt) begin
                if (w_load) begin
                    r_out_valid <= 1'b1;
                end else if (w_out_xfer) begin
                    r_out_valid <= 1'b0;
                end
            end
            if (w_load) begin
                r_pc      <= w_src_pc;
                r_instr   <= w_src_instr;
                r_imm_i   <= w_imm_i;
                r_imm_s   <= w_imm_s;
                r_imm_b   <= w_imm_b;
                r_imm_u   <= w_imm_u;
                r_imm_j   <= w_imm_j;
                r_imm_sel <= w_imm_sel;
                r_imm_fmt <= w_imm_fmt;
            end
        end
    end

    assign in_ready        = w_in_ready;
    assign out_valid       = r_out_valid;
    assign pc_out          = r_pc;
    assign instruction_out = r_instr;
    assign imm_i           = r_imm_i;
    assign imm_s           = r_imm_s;
    assign imm_b           = r_imm_b;
    assign imm_u           = r_imm_u;
    assign imm_j           = r_imm_j;
    assign imm_sel         = r_imm_sel;
    assign imm_fmt         = r_imm_fmt;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: XLEN=32 and XLEN=64 instances share stimulus and are checked every cycle
// against a queue model of the stage, plus directed literal checks.
module tb_operand_fetch_stage;

    localparam logic [31:0] RPC32 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, flush, halt, in_valid, out_ready;
    logic [63:0] pc_in;
    logic [31:0] instr_in;

    logic        rdy32, ov32, rdy64, ov64;
    logic [31:0] pc32, ins32, i32, s32, b32, u32, j32, sel32;
    logic [63:0] pc64, i64, s64, b64, u64, j64, sel64;
    logic [31:0] ins64;
    logic [2:0]  fmt32, fmt64;

    always #5 clk = ~clk;

    operand_fetch_stage #(.XLEN(32), .RESET_PC(RPC32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .halt(halt),
        .in_valid(in_valid), .in_ready(rdy32), .pc_in(pc_in[31:0]), .instruction_in(instr_in),
        .out_valid(ov32), .out_ready(out_ready), .pc_out(pc32), .instruction_out(ins32),
        .imm_i(i32), .imm_s(s32), .imm_b(b32), .imm_u(u32), .imm_j(j32),
        .imm_sel(sel32), .imm_fmt(fmt32)
    );

    operand_fetch_stage #(.XLEN(64), .RESET_PC(64'h0)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .halt(halt),
        .in_valid(in_valid), .in_ready(rdy64), .pc_in(pc_in), .instruction_in(instr_in),
        .out_valid(ov64), .out_ready(out_ready), .pc_out(pc64), .instruction_out(ins64),
        .imm_i(i64), .imm_s(s64), .imm_b(b64), .imm_u(u64), .imm_j(j64),
        .imm_sel(sel64), .imm_fmt(fmt64)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } entry_t;

    entry_t q[$];
    int checks = 0;
    int errors = 0;

    function automatic int m_fmt(input logic [31:0] ins);
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011: return 1;
            7'b0100011:                                     return 2;
            7'b1100011:                                     return 3;
            7'b0110111, 7'b0010111:                         return 4;
            7'b1101111:                                     return 5;
            default:                                        return 0;
        endcase
    endfunction

    // Immediate value as a signed number of its natural width, widened to 64 bits.
    function automatic logic [63:0] m_imm(input logic [31:0] ins, input int f);
        logic signed [11:0] v12;
        logic signed [12:0] v13;
        logic signed [20:0] v21;
        logic signed [31:0] v32;
        case (f)
            1: begin v12 = ins[31:20];                                            return 64'(v12); end
            2: begin v12 = {ins[31:25], ins[11:7]};                               return 64'(v12); end
            3: begin v13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};        return 64'(v13); end
            4: begin v32 = {ins[31:12], 12'h000};                                 return 64'(v32); end
            5: begin v21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};      return 64'(v21); end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic m_ready(input logic hl, input logic ordy, input int n);
`ifdef OF_SKID_BUFFER_EN
        return !hl && (n < 2);
`else
        return !hl && (n == 0 || ordy);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic        exp_v;
        logic        exp_rdy;
        entry_t      e;
        int          f;
        logic [63:0] e_imm;
        logic [63:0] a64[5];
        logic [31:0] a32[5];
        exp_v   = q.size() > 0;
        exp_rdy = m_ready(halt, out_ready, q.size());
        chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
        chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
        chk("out_valid32", 64'(ov32), 64'(exp_v));
        chk("out_valid64", 64'(ov64), 64'(exp_v));
        if (exp_v) begin
            e = q[0];
            f = m_fmt(e.ins);
            a64 = '{i64, s64, b64, u64, j64};
            a32 = '{i32, s32, b32, u32, j32};
            chk("pc32", 64'(pc32), {32'h0, e.pc[31:0]});
            chk("pc64", pc64, e.pc);
            chk("instr32", 64'(ins32), 64'(e.ins));
            chk("instr64", 64'(ins64), 64'(e.ins));
            chk("fmt32", 64'(fmt32), 64'(f));
            chk("fmt64", 64'(fmt64), 64'(f));
            for (int k = 1; k <= 5; k++) begin
                e_imm = m_imm(e.ins, k);
                chk("imm64", a64[k-1], e_imm);
                chk("imm32", 64'(a32[k-1]), {32'h0, e_imm[31:0]});
            end
            e_imm = (f == 0) ? 64'h0 : m_imm(e.ins, f);
            chk("sel64", sel64, e_imm);
            chk("sel32", 64'(sel32), {32'h0, e_imm[31:0]});
        end
    endtask

    // One clock: drive inputs, compare at negedge, advance model at posedge; returns whether input was taken.
    task automatic step(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic hl, output logic acc);
        logic   in_x, out_x;
        entry_t e;
        in_valid = iv; pc_in = pc; instr_in = ins; out_ready = ordy; flush = fl; halt = hl;
        @(negedge clk);
        compare_cycle();
        in_x  = iv && m_ready(hl, ordy, q.size());
        out_x = (q.size() > 0) && ordy && !hl;
        acc   = in_x;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (out_x) begin
                $display("xfer out pc=%h ins=%h", q[0].pc, q[0].ins);
                void'(q.pop_front());
            end
            if (in_x) begin
                e.pc = pc; e.ins = ins;
                q.push_back(e);
            end
        end
        #1;
    endtask

    logic [6:0] ops[10] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011, 7'b0100011,
                            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

    function automatic logic [31:0] rand_ins();
        logic [31:0] v;
        int          idx;
        v   = $urandom;
        idx = $urandom_range(0, 10);
        if (idx < 10) v[6:0] = ops[idx];
        return v;
    endfunction

    initial begin
        logic        acc, pending;
        logic [63:0] rpc;
        logic [31:0] rins;
        logic        bp_acc;

        rst = 1'b1; flush = 0; halt = 0; in_valid = 0; out_ready = 0; pc_in = '0; instr_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid32", 64'(ov32), 64'h0);
        chk("rst_valid64", 64'(ov64), 64'h0);
        chk("rst_pc32", 64'(pc32), 64'(RPC32));
        chk("rst_pc64", pc64, 64'h0);
        chk("rst_instr32", 64'(ins32), 64'h13);
        chk("rst_fmt32", 64'(fmt32), 64'h0);
        chk("rst_sel64", sel64, 64'h0);
        chk("rst_immi64", i64, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Model pins against hand-computed values.
        chk("model_addi", m_imm(32'hFFF0_0093, m_fmt(32'hFFF0_0093)), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("model_jal", m_imm(32'hFFDF_F06F, m_fmt(32'hFFDF_F06F)), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("model_lui", m_imm(32'h8000_00B7, 4), 64'hFFFF_FFFF_8000_0000);

        step(1, 64'h40, 32'hFFF0_0093, 1, 0, 0, acc);
        chk("addi_fmt32", 64'(fmt32), 64'h1);
        chk("addi_sel32", 64'(sel32), 64'hFFFF_FFFF);
        step(1, 64'h44, 32'hFFDF_F06F, 1, 0, 0, acc);
        chk("jal_fmt32", 64'(fmt32), 64'h5);
        chk("jal_sel32", 64'(sel32), 64'hFFFF_FFFC);
        step(1, 64'h48, 32'h1234_50B7, 1, 0, 0, acc);
        chk("lui_sel64", sel64, 64'h0000_0000_1234_5000);
        step(1, 64'h4C, 32'h8000_00B7, 1, 0, 0, acc);
        chk("lui_neg_sel64", sel64, 64'hFFFF_FFFF_8000_0000);
        step(0, 64'h0, 32'h0, 1, 0, 0, acc);
        chk("drain_valid32", 64'(ov32), 64'h0);

        // Backpressure: 0x100 held for 3 cycles while 0x104 waits upstream.
        step(1, 64'h100, rand_ins(), 0, 0, 0, acc);
        bp_acc = 1'b0;
        rins   = rand_ins();
        for (int c = 0; c < 3; c++) begin
            step(!bp_acc, 64'h104, rins, 0, 0, 0, acc);
            bp_acc = bp_acc | acc;
            chk("bp_hold_pc32", 64'(pc32), 64'h100);
        end
        step(!bp_acc, 64'h104, rins, 1, 0, 0, acc);
        chk("bp_next_pc32", 64'(pc32), 64'h104);
        chk("bp_next_valid32", 64'(ov32), 64'h1);
        step(0, 64'h0, 32'h0, 1, 0, 0, acc);
        chk("bp_no_dup", 64'(ov32), 64'h0);

        // Flush with held and incoming entries.
        step(1, 64'h200, rand_ins(), 0, 0, 0, acc);
        step(1, 64'h204, rand_ins(), 0, 1, 0, acc);
        chk("flush_valid32", 64'(ov32), 64'h0);
        chk("flush_valid64", 64'(ov64), 64'h0);

        // Halt freezes the stage even with out_ready high.
        step(1, 64'h300, rand_ins(), 0, 0, 0, acc);
        for (int c = 0; c < 3; c++) begin
            step(1, 64'h304, rand_ins(), 1, 0, 1, acc);
            chk("halt_ready32", 64'(rdy32), 64'h0);
            chk("halt_pc32", 64'(pc32), 64'h300);
        end
        step(1, 64'h308, rand_ins(), 1, 1, 1, acc);
        chk("flush_halt_valid32", 64'(ov32), 64'h0);

        // Asynchronous reset while an entry is held.
        step(1, 64'h400, rand_ins(), 0, 0, 0, acc);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid32", 64'(ov32), 64'h0);
        chk("arst_valid64", 64'(ov64), 64'h0);
        chk("arst_instr32", 64'(ins32), 64'h13);
        chk("arst_pc32", 64'(pc32), 64'(RPC32));
        q.delete();
        in_valid = 0; flush = 0; halt = 0;
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic; upstream holds an item until it is accepted.
        pending = 1'b1;
        rpc     = 64'h1000;
        rins    = rand_ins();
        for (int c = 0; c < 600; c++) begin
            logic iv, ordy, fl, hl;
            iv   = pending && ($urandom_range(0, 9) < 7);
            ordy = $urandom_range(0, 9) < 7;
            fl   = $urandom_range(0, 19) == 0;
            hl   = $urandom_range(0, 9) == 0;
            step(iv, rpc, rins, ordy, fl, hl, acc);
            if (acc || (fl && iv)) begin
                rpc  = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
                rins = rand_ins();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
